// File: rtl/pal_line_padder.sv
// pal_line_padder
//   Stretches the 262-line NTSC VDG field to a 312-line PAL field. It freezes
//   the VDG clock and emits synthetic blank lines in two places:
//     - TOP_LINES lines after the first Line24 rise of a field
//     - BOTTOM_LINES lines at the FSn falling edge
//
// Ports
//   CLK        system clock (14.318 MHz)
//   RST        asynchronous active-high reset
//   HSn        VDG horizontal sync (async, active low)
//   FSn        VDG field sync (async, active low)
//   Line24     line counter flag, high for lines 24-31, 56-63, ...
//   VdgClkEn   1 = VDG clock runs, 0 = VDG frozen
//   HSyncPadN  synthetic HSync (active low), meaningful while PadActive
//   PadActive  high during any padding line
//   PadLine    index of the current padding line
module pal_line_padder #(
    parameter int TOP_LINES    = 25,
    parameter int BOTTOM_LINES = 25,
    parameter int LINE_CLKS    = 912,
    parameter int HS_WIDTH     = 67
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       HSn,
    input  logic       FSn,
    input  logic       Line24,
    output logic       VdgClkEn,
    output logic       HSyncPadN,
    output logic       PadActive,
    output logic [5:0] PadLine
);

    // Parameter range checks, evaluated at elaboration
    if (TOP_LINES < 1 || TOP_LINES > 63) begin : g_bad_top
        $error("pal_line_padder: TOP_LINES out of range 1..63");
    end
    if (BOTTOM_LINES < 1 || BOTTOM_LINES > 63) begin : g_bad_bottom
        $error("pal_line_padder: BOTTOM_LINES out of range 1..63");
    end
    if (LINE_CLKS < 64 || LINE_CLKS > 1023) begin : g_bad_line
        $error("pal_line_padder: LINE_CLKS out of range 64..1023");
    end
    if (HS_WIDTH < 1 || HS_WIDTH >= LINE_CLKS) begin : g_bad_hs
        $error("pal_line_padder: HS_WIDTH out of range 1..LINE_CLKS-1");
    end

    localparam logic [9:0] LAST_CLK = 10'(LINE_CLKS - 1);
    localparam logic [9:0] HS_END   = 10'(HS_WIDTH);
    localparam logic [5:0] TOP_LAST = 6'(TOP_LINES - 1);
    localparam logic [5:0] BOT_LAST = 6'(BOTTOM_LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT_FS,
        TOP_PAD,
        BOTTOM_PAD
    } state_t;

    state_t     state, state_next;
    logic       armed, armed_next;
    logic [9:0] clk_cnt;
    logic [5:0] pad_line;

    // Synchronisers. Bit [1] is the synchronised value. Bit [2] holds the
    // previous synchronised value and is used only for edge detection.
    logic [1:0] hsn_sync;
    logic [2:0] fsn_sync;
    logic [2:0] l24_sync;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hsn_sync <= '1;
            fsn_sync <= '1;
            l24_sync <= '0;
        end else begin
            hsn_sync <= {hsn_sync[0], HSn};
            fsn_sync <= {fsn_sync[1:0], FSn};
            l24_sync <= {l24_sync[1:0], Line24};
        end
    end

    // Padding timing is generated locally, so synchronised HSn has no
    // consumer inside this block.
    logic unused_hsn;
    assign unused_hsn = hsn_sync[1];

    logic fs_rise, fs_fall, l24_rise;
    assign fs_rise  =  fsn_sync[1] & ~fsn_sync[2];
    assign fs_fall  = ~fsn_sync[1] &  fsn_sync[2];
    assign l24_rise =  l24_sync[1] & ~l24_sync[2];

    logic padding, line_end, last_line, pad_done;
    assign padding   = (state == TOP_PAD) || (state == BOTTOM_PAD);
    assign line_end  = (clk_cnt == LAST_CLK);
    assign last_line = (pad_line == ((state == TOP_PAD) ? TOP_LAST : BOT_LAST));
    assign pad_done  = padding && line_end && last_line;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= armed_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        armed_next = armed;
        unique case (state)
            IDLE: begin
                if (fs_rise) begin
                    state_next = ARMED;
                    armed_next = 1'b1;
                end
            end
            ARMED: begin
                // A field sync wins over a simultaneous Line24 rise. If the
                // field ends before Line24 is seen, the top pad is skipped.
                if (fs_fall) begin
                    state_next = BOTTOM_PAD;
                    armed_next = 1'b0;
                end else if (l24_rise && armed) begin
                    state_next = TOP_PAD;
                    armed_next = 1'b0;
                end
            end
            WAIT_FS: begin
                if (fs_fall) state_next = BOTTOM_PAD;
            end
            TOP_PAD: begin
                if (pad_done) state_next = WAIT_FS;
            end
            BOTTOM_PAD: begin
                if (pad_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Line and clock counters. Both are held at zero outside padding, so a
    // new pad always starts at line 0 with HSync low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clk_cnt  <= '0;
            pad_line <= '0;
        end else if (padding) begin
            if (line_end) begin
                clk_cnt  <= '0;
                pad_line <= last_line ? 6'd0 : pad_line + 6'd1;
            end else begin
                clk_cnt <= clk_cnt + 10'd1;
            end
        end else begin
            clk_cnt  <= '0;
            pad_line <= '0;
        end
    end

    // Outputs decode directly from state, so reset restores them without a
    // clock edge.
    always_comb begin
        VdgClkEn  = 1'b1;
        PadActive = 1'b0;
        HSyncPadN = 1'b1;
        if (padding) begin
            VdgClkEn  = 1'b0;
            PadActive = 1'b1;
            HSyncPadN = (clk_cnt >= HS_END);
        end
    end

    assign PadLine = pad_line;

endmodule

// File: doc/pal_line_padder.md
Name: pal_line_padder

Overview:
- Downstream consumer of the VDG line counter's Line24 flag and of the VDG HSn/FSn syncs.
- Stretches the 262-line NTSC VDG field to 312-line PAL by freezing the VDG clock and emitting synthetic blank lines.
- Inserts TOP_LINES blank lines after line 24 and BOTTOM_LINES blank lines at field sync.
- Sits between the system clock generator and the VDG clock gate / composite sync mixer.

Parameters:
- TOP_LINES, 25, padding lines inserted after Line24 rises (1..63)
- BOTTOM_LINES, 25, padding lines inserted at FSn falling edge (1..63)
- LINE_CLKS, 912, CLK cycles per synthetic line (64..1023)
- HS_WIDTH, 67, CLK cycles synthetic HSync is low at start of each padding line (1..LINE_CLKS-1)

Ports:
- CLK  in  1  system clock (14.318 MHz); all state on rising edge
- RST  in  1  asynchronous, active-high reset
- HSn  in  1  VDG horizontal sync, active low, asynchronous to CLK
- FSn  in  1  VDG field sync, active low, asynchronous to CLK
- Line24  in  1  from line counter; high for lines 24-31, 56-63, ...
- VdgClkEn  out  1  1 = VDG clock runs, 0 = VDG frozen
- HSyncPadN  out  1  synthetic HSync, active low, valid only while PadActive
- PadActive  out  1  high during any padding line
- PadLine  out  6  index of current padding line (0-based)

Behaviour:
- Synchronisers: HSn, FSn and Line24 each pass through 2 CLK flops; edges are detected on the synchronised values.
- Reset (async, RST=1): state IDLE, armed=0, VdgClkEn=1, HSyncPadN=1, PadActive=0, PadLine=0, line/clock counters 0, synchroniser flops 1 (HSn, FSn) and 0 (Line24).
- States:
  - IDLE: wait for synced FSn rising edge -> ARMED, armed=1.
  - ARMED: on synced Line24 rising edge with armed=1 -> TOP_PAD, armed=0. On synced FSn falling edge -> BOTTOM_PAD.
  - WAIT_FS: reached after TOP_PAD; on synced FSn falling edge -> BOTTOM_PAD. Line24 edges are ignored, so only one top pad per field.
  - TOP_PAD / BOTTOM_PAD: VdgClkEn=0, PadActive=1.
    - Clock counter runs 0..LINE_CLKS-1; HSyncPadN=0 while clock counter < HS_WIDTH, else 1.
    - At LINE_CLKS-1 the clock counter wraps to 0 and PadLine increments.
    - After the clock wrap on PadLine = TOP_LINES-1 (or BOTTOM_LINES-1): TOP_PAD -> WAIT_FS, BOTTOM_PAD -> IDLE.
    - On exit: VdgClkEn=1, PadActive=0, HSyncPadN=1, PadLine=0.
- Latency:
  - VdgClkEn falls on the 3rd CLK rising edge after the triggering input edge (2 sync + 1 register).
  - First padding line's HSyncPadN low begins the same cycle.
- Exact padding length: VdgClkEn stays low for exactly N*LINE_CLKS cycles (N = TOP_LINES or BOTTOM_LINES).
- FSn falling while in ARMED (Line24 never seen, e.g. short field): skip top pad, go directly to BOTTOM_PAD, armed=0.
- FSn edges during TOP_PAD/BOTTOM_PAD: ignored; the VDG is frozen, so these only arise from glitches.
- Line24 high at the moment ARMED is entered: no trigger; a rising edge is required.
- Reset mid-pad: immediate return to IDLE values; VdgClkEn=1 asynchronously.
- Line24 rise and FSn fall synchronised in the same cycle while in ARMED: FSn wins (BOTTOM_PAD).
- Counters: clock counter 10 bits, PadLine 6 bits. No wrap beyond parameter limits is permitted; parameters are checked by elaboration-time assertion.

Test Plan:
- Reset release, FSn held low then raised -> IDLE then ARMED after 3 CLKs; VdgClkEn=1, PadActive=0 throughout.
- FSn high, Line24 0->1 -> VdgClkEn=0 at edge 3, PadActive=1, HSyncPadN low for 67 CLKs per line. Exactly 25*912=22800 CLKs later VdgClkEn=1 and state is WAIT_FS.
- Second Line24 rising (line 56) in WAIT_FS -> no padding, VdgClkEn stays 1.
- FSn falling in WAIT_FS -> 25 bottom lines (22800 CLKs, PadLine counts 0..24); then IDLE; next FSn rise re-arms.
- FSn falling in ARMED with no Line24 -> BOTTOM_PAD directly; no TOP_PAD in that field.
- RST asserted at PadLine=10 mid-line -> VdgClkEn=1, PadActive=0, HSyncPadN=1, PadLine=0 without a clock edge; after release, the block waits for an FSn rise before padding again.
